// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/PC+4 results and loads into the register file as one-cycle write pulses.
// Optional macro WB_BYPASS_EN adds a same-cycle forward of load data (fwd_valid).
module wb_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [4:0]  ex_rd,
   input  logic [1:0]  ex_wb_sel,
   input  logic [31:0] ex_result,
   input  logic [31:0] ex_pc4,
   input  logic [2:0]  ex_funct3,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [31:0] rd_write_data,
   output logic        wb_err,
`ifdef WB_BYPASS_EN
   output logic        fwd_valid,
`endif
   output logic        dbg_state
);

   // Handshake: an instruction is accepted on a rising edge where ex_valid && ex_ready;
   // ex_ready is high exactly while the FSM is IDLE, and ex_valid is ignored otherwise.
   typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [4:0]  ld_rd;
   logic [2:0]  ld_f3;
   logic [1:0]  ld_addr;
   logic [7:0]  tmo_cnt;
   logic [4:0]  rd_q;
   logic [31:0] data_q;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_data;
   logic        ld_bad;

   always_comb begin
      lane_b = mem_rdata[7:0];
      case (ld_addr)
         2'd1:    lane_b = mem_rdata[15:8];
         2'd2:    lane_b = mem_rdata[23:16];
         2'd3:    lane_b = mem_rdata[31:24];
         default: lane_b = mem_rdata[7:0];
      endcase
      lane_h = ld_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_f3)
         3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_data = {24'd0, lane_b};
         3'b101:  ld_data = {16'd0, lane_h};
         default: ld_data = mem_rdata;
      endcase
   end

   // Misaligned addresses and unsupported funct3 codes are rejected at accept time.
   always_comb begin
      case (ex_funct3)
         3'b000, 3'b100: ld_bad = 1'b0;
         3'b001, 3'b101: ld_bad = ex_result[0];
         3'b010:         ld_bad = |ex_result[1:0];
         default:        ld_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ld_rd     <= '0;
         ld_f3     <= '0;
         ld_addr   <= '0;
         tmo_cnt   <= '0;
         rd_q      <= '0;
         data_q    <= '0;
         reg_write <= 1'b0;
         wb_err    <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_rvalid) wb_err <= 1'b1;
               if (ex_valid) begin
                  case (ex_wb_sel)
                     2'd1, 2'd3: begin
                        if (ex_rd != 5'd0) begin
                           reg_write <= 1'b1;
                           rd_q      <= ex_rd;
                           data_q    <= (ex_wb_sel == 2'd1) ? ex_result : ex_pc4;
                        end
                     end
                     2'd2: begin
                        if (ld_bad) begin
                           wb_err <= 1'b1;
                        end else begin
                           ld_rd   <= ex_rd;
                           ld_f3   <= ex_funct3;
                           ld_addr <= ex_result[1:0];
                           tmo_cnt <= '0;
                           state   <= WAIT_MEM;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            WAIT_MEM: begin
               // A response on the final counted cycle beats the timeout.
               if (mem_rvalid) begin
                  if (ld_rd != 5'd0) begin
                     reg_write <= 1'b1;
                     rd_q      <= ld_rd;
                     data_q    <= ld_data;
                  end
                  state <= IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  wb_err <= 1'b1;
                  state  <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ex_ready  = (state == IDLE);
   assign dbg_state = logic'(state);

`ifdef WB_BYPASS_EN
   assign fwd_valid     = (state == WAIT_MEM) && mem_rvalid && (ld_rd != 5'd0);
   assign rd            = fwd_valid ? ld_rd : rd_q;
   assign rd_write_data = fwd_valid ? ld_data : data_q;
`else
   assign rd            = rd_q;
   assign rd_write_data = data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then randomized traffic, checked against a transaction-level model.
module tb_wb_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [4:0]  ex_rd = '0;
   logic [1:0]  ex_wb_sel = '0;
   logic [31:0] ex_result = '0;
   logic [31:0] ex_pc4 = '0;
   logic [2:0]  ex_funct3 = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] rd_write_data;
   logic        wb_err;
   logic        dbg_state;
`ifdef WB_BYPASS_EN
   logic        fwd_valid;
`endif

   wb_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_result(ex_result), .ex_pc4(ex_pc4),
      .ex_funct3(ex_funct3), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_write(reg_write), .rd(rd), .rd_write_data(rd_write_data), .wb_err(wb_err),
`ifdef WB_BYPASS_EN
      .fwd_valid(fwd_valid),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // scoreboard: expected {rd, data} writes
   logic [36:0] exp_q[$];
   logic        m_busy;
   logic        m_err;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   logic [1:0]  m_addr;
   int          m_wait;
   logic [4:0]  last_rd;
   logic [31:0] last_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] a);
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
      if (f3 == 3'd2 && a != 2'd0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> (8 * a);
      case (f3)
         3'd0:    return 32'($signed(sh[7:0]));
         3'd1:    return 32'($signed(sh[15:0]));
         3'd4:    return {24'd0, sh[7:0]};
         3'd5:    return {16'd0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
      if (r != 5'd0) begin
         exp_q.push_back({r, d});
         last_rd = r;
         last_data = d;
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_err = 1'b0; m_rd = '0; m_f3 = '0; m_addr = '0; m_wait = 0;
      last_rd = '0; last_data = '0;
      exp_q.delete();
   endtask

   task automatic model(input logic v, input logic [4:0] r, input logic [1:0] sel,
                        input logic [31:0] res, input logic [31:0] pc4,
                        input logic [2:0] f3, input logic rv, input logic [31:0] rdata);
      if (!m_busy) begin
         if (rv) m_err = 1'b1;
         if (v) begin
            case (sel)
               2'd1: push_wr(r, res);
               2'd3: push_wr(r, pc4);
               2'd2: begin
                  if (load_bad(f3, res[1:0])) m_err = 1'b1;
                  else begin
                     m_busy = 1'b1; m_rd = r; m_f3 = f3; m_addr = res[1:0]; m_wait = 0;
                  end
               end
               default: ;
            endcase
         end
      end else if (rv) begin
         push_wr(m_rd, load_val(m_f3, m_addr, rdata));
         m_busy = 1'b0;
      end else begin
         m_wait++;
         if (m_wait == TMO) begin
            m_err = 1'b1;
            m_busy = 1'b0;
         end
      end
   endtask

   task automatic compare();
      logic [36:0] e;
      chk("reg_write", reg_write, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rd", rd, e[36:32]);
         chk("rd_write_data", rd_write_data, e[31:0]);
      end else begin
         chk("rd_hold", rd, last_rd);
         chk("data_hold", rd_write_data, last_data);
      end
      chk("wb_err", wb_err, m_err);
      chk("ex_ready", ex_ready, !m_busy);
      chk("state", dbg_state, m_busy);
   endtask

   // driver: apply one cycle of inputs, advance the model, sample after the edge
   task automatic step(input logic v, input logic [4:0] r, input logic [1:0] sel,
                       input logic [31:0] res, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic rv, input logic [31:0] rdata);
      ex_valid = v; ex_rd = r; ex_wb_sel = sel; ex_result = res; ex_pc4 = pc4;
      ex_funct3 = f3; mem_rvalid = rv; mem_rdata = rdata;
      model(v, r, sel, res, pc4, f3, rv, rdata);
      @(negedge clk);
      ex_valid = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      compare();
   endtask

   task automatic idle_step();
      step(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_reg_write", reg_write, 1'b0);
      chk("rst_rd", rd, 5'd0);
      chk("rst_data", rd_write_data, 32'd0);
      chk("rst_wb_err", wb_err, 1'b0);
      chk("rst_ex_ready", ex_ready, 1'b1);
      chk("rst_state", dbg_state, 1'b0);
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic        v;
      logic [4:0]  r;
      logic [1:0]  sel;
      logic [31:0] res;
      logic [2:0]  f3;
      logic        rv;
      logic [2:0]  valid_f3[5];
      valid_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      model_reset();
      @(negedge clk);
      do_reset();
      @(negedge clk);

      // ALU write
      step(1'b1, 5'd5, 2'd1, 32'hDEADBEEF, 32'd0, 3'd0, 1'b0, 32'd0);
      chk("alu_data", rd_write_data, 32'hDEADBEEF);
      idle_step();

      // LB with response three cycles after accept
      step(1'b1, 5'd7, 2'd2, 32'h00001003, 32'd0, 3'd0, 1'b0, 32'd0);
      idle_step();
      idle_step();
      step(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h80112233);
      chk("lb_data", rd_write_data, 32'hFFFFFF80);

      // LHU upper half, then misaligned LH
      step(1'b1, 5'd9, 2'd2, 32'h00002002, 32'd0, 3'd5, 1'b0, 32'd0);
      step(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h8001ABCD);
      chk("lhu_data", rd_write_data, 32'h00008001);
      step(1'b1, 5'd9, 2'd2, 32'h00002001, 32'd0, 3'd1, 1'b0, 32'd0);
      chk("lh_misaligned_err", wb_err, 1'b1);

      // LW timeout
      do_reset();
      step(1'b1, 5'd3, 2'd2, 32'h00000100, 32'd0, 3'd2, 1'b0, 32'd0);
      for (int i = 0; i < TMO; i++) idle_step();
      chk("timeout_err", wb_err, 1'b1);

      // JAL to x0, then PC+4 to x1
      step(1'b1, 5'd0, 2'd3, 32'd0, 32'h00000104, 3'd0, 1'b0, 32'd0);
      step(1'b1, 5'd1, 2'd3, 32'd0, 32'h00000104, 3'd0, 1'b0, 32'd0);
      chk("jal_data", rd_write_data, 32'h00000104);

      // timeout boundary: response on the last counted cycle wins
      do_reset();
      step(1'b1, 5'd4, 2'd2, 32'h00000000, 32'd0, 3'd2, 1'b0, 32'd0);
      for (int i = 0; i < TMO - 1; i++) idle_step();
      step(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h12345678);

      // reset during a load, then a stale response
      do_reset();
      step(1'b1, 5'd6, 2'd2, 32'h00000000, 32'd0, 3'd2, 1'b0, 32'd0);
      idle_step();
      #2;
      do_reset();
      @(negedge clk);
      step(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b1, 32'hCAFEF00D);

      // randomized phases, reset between them so the sticky error does not mask later checks
      for (int p = 0; p < 6; p++) begin
         do_reset();
         @(negedge clk);
         for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            sel = 2'($urandom_range(0, 3));
            f3  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7))
                                                : valid_f3[$urandom_range(0, 4)];
            res = $urandom;
            if ($urandom_range(0, 9) < 6 && f3 != 3'd0 && f3 != 3'd4)
               res[1:0] = (f3 == 3'd2) ? 2'd0 : {res[1], 1'b0};
            if (m_busy) rv = ($urandom_range(0, 3) == 0);
            else        rv = ($urandom_range(0, 79) == 0);
            step(v, r, sel, res, $urandom, f3, rv, $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
